// File: rtl/divmod_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divmod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int MODE_REM    = 0;
  localparam int MODE_SIGNED = 1;

  // Counter must hold WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divmod_iter_core_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module divmod_iter_core_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, dsr_i});
    // Only meaningful when fits; the result is then below the divisor.
    diff   = rem_sh[WIDTH-1:0] - dsr_i;
    rem_o  = fits ? diff : rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divmod_iter_core.sv
// Iterative radix-2 restoring divider, signed/unsigned, constant latency,
// with divide-by-zero flag and busy/valid handshake.
module divmod_iter_core
  import divmod_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       mode,
  input  logic             valid_input,
  output logic             busy,
  output logic             valid_output,
  output logic [WIDTH-1:0] final_output,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             valid_output_q, valid_output_d;
  logic [WIDTH-1:0] final_output_q, final_output_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] q_fix, r_fix;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  divmod_iter_core_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dvd_d          = dvd_q;
    dsr_d          = dsr_q;
    mode_d         = mode_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    q_neg_d        = q_neg_q;
    r_neg_d        = r_neg_q;
    dz_d           = dz_q;
    valid_output_d = 1'b0;
    final_output_d = final_output_q;
    div_by_zero_d  = div_by_zero_q;
    sgn            = SIGNED_EN && mode_q[MODE_SIGNED];
    a_neg          = sgn & dvd_q[WIDTH-1];
    b_neg          = sgn & dsr_q[WIDTH-1];
    q_fix          = q_neg_q ? negate(quo_q) : quo_q;
    r_fix          = r_neg_q ? negate(rem_q) : rem_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_input) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          mode_d  = mode;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        quo_d   = a_neg ? negate(dvd_q) : dvd_q;
        dsr_d   = b_neg ? negate(dsr_q) : dsr_q;
        rem_d   = '0;
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        dz_d    = (dsr_q == '0);
        cnt_d   = CW'(WIDTH - 1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        quo_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        // Zero divisor overrides whatever the iteration left behind.
        if (dz_q) begin
          q_fix = '1;
          r_fix = dvd_q;
        end
        quo_d   = mode_q[MODE_REM] ? r_fix : q_fix;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        final_output_d = quo_q;
        div_by_zero_d  = dz_q;
        valid_output_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Busy stays up through the valid_output cycle that follows DONE.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      dvd_q          <= '0;
      dsr_q          <= '0;
      mode_q         <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      q_neg_q        <= 1'b0;
      r_neg_q        <= 1'b0;
      dz_q           <= 1'b0;
      busy_q         <= 1'b0;
      valid_output_q <= 1'b0;
      final_output_q <= '0;
      div_by_zero_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dvd_q          <= dvd_d;
      dsr_q          <= dsr_d;
      mode_q         <= mode_d;
      quo_q          <= quo_d;
      rem_q          <= rem_d;
      q_neg_q        <= q_neg_d;
      r_neg_q        <= r_neg_d;
      dz_q           <= dz_d;
      busy_q         <= busy_d;
      valid_output_q <= valid_output_d;
      final_output_q <= final_output_d;
      div_by_zero_q  <= div_by_zero_d;
    end
  end

  assign busy         = busy_q;
  assign valid_output = valid_output_q;
  assign final_output = final_output_q;
  assign div_by_zero  = div_by_zero_q;

endmodule

// File: tb/tb_divmod_iter_core.sv
// Scoreboard bench for divmod_iter_core (WIDTH=8), signed and unsigned builds.
module tb_divmod_iter_core;

  typedef struct {
    logic [7:0] out;
    logic       dz;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dividend = '0, divisor = '0;
  logic [1:0] mode = '0;
  logic       valid_input = 1'b0;
  logic       busy, valid_output, div_by_zero;
  logic [7:0] final_output;

  logic [7:0] dividend_u = '0, divisor_u = '0;
  logic [1:0] mode_u = '0;
  logic       valid_u_in = 1'b0;
  logic       busy_u, valid_u, dz_u;
  logic [7:0] out_u;

  exp_t sb_q[$];
  exp_t sb_u[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   model_acc = -100;
  logic [7:0] model_out = '0;
  logic       model_dz = 1'b0;
  logic       mon_en = 1'b0;

  divmod_iter_core #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
    .mode(mode), .valid_input(valid_input), .busy(busy),
    .valid_output(valid_output), .final_output(final_output),
    .div_by_zero(div_by_zero)
  );

  divmod_iter_core #(.WIDTH(8), .SIGNED_EN(1'b0)) u_uns (
    .clk(clk), .reset(reset), .dividend(dividend_u), .divisor(divisor_u),
    .mode(mode_u), .valid_input(valid_u_in), .busy(busy_u),
    .valid_output(valid_u), .final_output(out_u), .div_by_zero(dz_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every valid_output and checks held state each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (valid_output) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid got pulse expected none at cycle %0d", cyc);
          end else begin
            e = sb_q.pop_front();
            check("result", int'(final_output), int'(e.out));
            check("dz_flag", int'(div_by_zero), int'(e.dz));
            check("latency_cycle", cyc, e.cyc);
            model_out = e.out;
            model_dz  = e.dz;
          end
        end
        check("busy", int'(busy), int'(cyc >= model_acc && cyc <= model_acc + 11));
        check("held_output", int'(final_output), int'(model_out));
        check("held_dz", int'(div_by_zero), int'(model_dz));
        if (valid_u) begin
          if (sb_u.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid_u got pulse expected none at cycle %0d", cyc);
          end else begin
            e = sb_u.pop_front();
            check("uns_result", int'(out_u), int'(e.out));
            check("uns_dz", int'(dz_u), int'(e.dz));
            check("uns_latency", cyc, e.cyc);
            check("uns_busy", int'(busy_u), 1);
          end
        end
      end
    end
  end

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic [7:0] q, input logic dz);
    exp_t e;
    dividend = a; divisor = b; mode = m; valid_input = 1'b1;
    @(posedge clk); #2;
    valid_input = 1'b0;
    model_acc = cyc;
    e.out = q; e.dz = dz; e.cyc = cyc + 11;
    sb_q.push_back(e);
  endtask

  task automatic accept_u(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input logic [7:0] q);
    exp_t e;
    dividend_u = a; divisor_u = b; mode_u = m; valid_u_in = 1'b1;
    @(posedge clk); #2;
    valid_u_in = 1'b0;
    e.out = q; e.dz = 1'b0; e.cyc = cyc + 11;
    sb_u.push_back(e);
  endtask

  task automatic slot();
    repeat (11) @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(valid_output), 0);
    @(posedge clk); #2;

    accept(8'd100, 8'd7, 2'b00, 8'h0E, 1'b0); slot();
    accept(8'd100, 8'd7, 2'b01, 8'h02, 1'b0); slot();
    accept(8'h9C,  8'h07, 2'b10, 8'hF2, 1'b0); slot();
    accept(8'h9C,  8'h07, 2'b11, 8'hFE, 1'b0); slot();
    accept(8'h64,  8'hF9, 2'b10, 8'hF2, 1'b0); slot();
    accept(8'h64,  8'hF9, 2'b11, 8'h02, 1'b0); slot();
    accept(8'd55,  8'd0,  2'b00, 8'hFF, 1'b1); slot();
    accept(8'd55,  8'd0,  2'b01, 8'd55, 1'b1); slot();
    accept(8'h80,  8'hFF, 2'b10, 8'h80, 1'b0); slot();
    accept(8'h80,  8'hFF, 2'b11, 8'h00, 1'b0); slot();
    accept(8'h9C,  8'h07, 2'b00, 8'h16, 1'b0); slot();
    accept(8'hF9,  8'hFE, 2'b10, 8'h03, 1'b0); slot();
    accept(8'hF9,  8'hFE, 2'b11, 8'hFF, 1'b0); slot();
    accept(8'd7,   8'd100, 2'b01, 8'd7, 1'b0); slot();

    // Request held high for 30 cycles: only three accepts, 12 cycles apart.
    dividend = 8'd200; divisor = 8'd9; mode = 2'b00; valid_input = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (i % 12 == 0) begin
        model_acc = cyc;
        e.out = 8'h16; e.dz = 1'b0; e.cyc = cyc + 11;
        sb_q.push_back(e);
      end
    end
    valid_input = 1'b0;
    repeat (6) @(posedge clk);
    #2;

    // Reset five cycles into an operation aborts it silently.
    accept(8'd100, 8'd7, 2'b00, 8'h0E, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    model_acc = -100;
    model_out = '0;
    model_dz  = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    accept(8'd100, 8'd7, 2'b01, 8'h02, 1'b0); slot();

    // SIGNED_EN=0 build ignores mode[1].
    accept_u(8'h80, 8'hFF, 2'b10, 8'h00); slot();
    accept_u(8'h80, 8'hFF, 2'b11, 8'h80); slot();

    repeat (15) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size() + sb_u.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
